// File: rtl/prom_pgm_pkg.sv
// Shared types for the PROM programmer: FSM state encoding and completion codes.
package prom_pgm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_SETUP = 3'd1,
    RD_CLK   = 3'd2,
    RD_CMP   = 3'd3,
    PULSE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_UNBLOW = 2'd1;
  localparam logic [1:0] ERR_RETRY  = 2'd2;

endpackage

// File: rtl/prom_programmer_if.sv
// Host-side write request/acknowledge bundle between a loader sequencer and the PROM programmer.
interface prom_programmer_if #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 9
);
  logic              req;
  logic [AWIDTH-1:0] wa;
  logic [WIDTH-1:0]  wd;
  logic              busy;
  logic              ack;
  logic              err;
  logic [1:0]        errcode;

  modport master (output req, wa, wd, input busy, ack, err, errcode);
  modport slave  (input req, wa, wd, output busy, ack, err, errcode);
endinterface

// File: rtl/prom_pgm_bitsel.sv
// Priority encoder over a PROM readback: picks the lowest bit still to be blown (q=1, wd=0)
// and flags bits that would need un-blowing (q=0, wd=1).
module prom_pgm_bitsel #(
  parameter  int WIDTH = 8,
  localparam int BW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] wd,
  output logic [BW-1:0]    idx,
  output logic             none,
  output logic             unblow
);

  logic [WIDTH-1:0] need;
  logic [WIDTH-1:0] first;
  logic [WIDTH:0]   lower;

  assign need     = q & ~wd;
  assign lower[0] = 1'b0;

  // lower[k] = some bit below k still needs blowing; first is one-hot on the lowest such bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pri
      assign lower[gi+1] = lower[gi] | need[gi];
      assign first[gi]   = need[gi] & ~lower[gi];
    end
  endgenerate

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (first[i]) idx = idx | BW'(i);
    end
  end

  assign none   = ~lower[WIDTH];
  assign unblow = |(wd & ~q);

endmodule

// File: rtl/prom_programmer.sv
// Programmer for the 512x8 registered bipolar PROM: read back, pulse one fuse at a time, re-verify.
// Define PROM_PGM_PULSECNT_EN to add the saturating pulse_cnt[15:0] fuse-pulse counter output.
module prom_programmer
  import prom_pgm_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int AWIDTH    = 9,
  parameter  int PULSE_CYC = 10,
  parameter  int MAX_TRIES = 4,
  localparam int BW        = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  prom_programmer_if.slave  host,
  output logic [AWIDTH-1:0] a,
  output logic              e1_,
  output logic              e2_,
  output logic              dclk,
  input  logic [WIDTH-1:0]  q,
  output logic              pgm,
  output logic [BW-1:0]     bsel
`ifdef PROM_PGM_PULSECNT_EN
  ,
  output logic [15:0]       pulse_cnt
`endif
);

  state_t             state_q, state_d;
  logic [AWIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]   wd_q, wd_d;
  logic               en_n_q, en_n_d;
  logic               dclk_q, dclk_d;
  logic               pgm_q, pgm_d;
  logic [BW-1:0]      bsel_q, bsel_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [1:0]         errcode_q, errcode_d;
  logic [3:0]         tries_q, tries_d;
  logic [BW-1:0]      tbit_q, tbit_d;
  logic [7:0]         pcyc_q, pcyc_d;
  logic [3:0]         eff_tries;
`ifdef PROM_PGM_PULSECNT_EN
  logic [15:0]        pcnt_q, pcnt_d;
`endif

  logic [BW-1:0]      bs_idx;
  logic               bs_none;
  logic               bs_unblow;

  prom_pgm_bitsel #(.WIDTH(WIDTH)) u_bitsel (
    .q      (q),
    .wd     (wd_q),
    .idx    (bs_idx),
    .none   (bs_none),
    .unblow (bs_unblow)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    wd_d      = wd_q;
    bsel_d    = bsel_q;
    err_d     = err_q;
    errcode_d = errcode_q;
    tries_d   = tries_q;
    tbit_d    = tbit_q;
    pcyc_d    = pcyc_q;
`ifdef PROM_PGM_PULSECNT_EN
    pcnt_d    = pcnt_q;
`endif
    // Moving on to a different bit restarts its try budget.
    eff_tries = (bs_idx == tbit_q) ? tries_q : 4'd0;

    case (state_q)
      IDLE: begin
        if (host.req) begin
          state_d = RD_SETUP;
          a_d     = host.wa;
          wd_d    = host.wd;
          tries_d = 4'd0;
        end
      end
      RD_SETUP: state_d = RD_CLK;
      RD_CLK:   state_d = RD_CMP;
      RD_CMP: begin
        if (bs_none && !bs_unblow) begin
          state_d   = DONE;
          err_d     = 1'b0;
          errcode_d = ERR_OK;
        end else if (bs_unblow) begin
          state_d   = DONE;
          err_d     = 1'b1;
          errcode_d = ERR_UNBLOW;
        end else if (eff_tries >= 4'(MAX_TRIES)) begin
          state_d   = DONE;
          err_d     = 1'b1;
          errcode_d = ERR_RETRY;
        end else begin
          state_d = PULSE;
          tries_d = eff_tries + 4'd1;
          tbit_d  = bs_idx;
          bsel_d  = bs_idx;
          pcyc_d  = 8'(PULSE_CYC - 1);
`ifdef PROM_PGM_PULSECNT_EN
          if (pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
`endif
        end
      end
      PULSE: begin
        if (pcyc_q == 8'd0) state_d = RD_SETUP;
        else                pcyc_d  = pcyc_q - 8'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin levels follow the state being entered so every output comes straight from a flop.
    en_n_d = !(state_d == RD_SETUP || state_d == RD_CLK || state_d == RD_CMP);
    dclk_d = (state_d == RD_CLK);
    pgm_d  = (state_d == PULSE);
    busy_d = (state_d != IDLE);
    ack_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      wd_q      <= '0;
      en_n_q    <= 1'b1;
      dclk_q    <= 1'b0;
      pgm_q     <= 1'b0;
      bsel_q    <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      errcode_q <= ERR_OK;
      tries_q   <= 4'd0;
      tbit_q    <= '0;
      pcyc_q    <= 8'd0;
`ifdef PROM_PGM_PULSECNT_EN
      pcnt_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      wd_q      <= wd_d;
      en_n_q    <= en_n_d;
      dclk_q    <= dclk_d;
      pgm_q     <= pgm_d;
      bsel_q    <= bsel_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      errcode_q <= errcode_d;
      tries_q   <= tries_d;
      tbit_q    <= tbit_d;
      pcyc_q    <= pcyc_d;
`ifdef PROM_PGM_PULSECNT_EN
      pcnt_q    <= pcnt_d;
`endif
    end
  end

  assign a            = a_q;
  assign e1_          = en_n_q;
  assign e2_          = en_n_q;
  assign dclk         = dclk_q;
  assign pgm          = pgm_q;
  assign bsel         = bsel_q;
  assign host.busy    = busy_q;
  assign host.ack     = ack_q;
  assign host.err     = err_q;
  assign host.errcode = errcode_q;
`ifdef PROM_PGM_PULSECNT_EN
  assign pulse_cnt    = pcnt_q;
`endif

endmodule
